// File: rtl/ifetch_unit.sv
// Instruction fetch unit: two-state REQ/ISSUE machine that fetches one word,
// holds it in the IR for a ready/valid handshake, then advances the PC.
`timescale 1ns/1ps
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [5:0]  OpCode,
    output logic [5:0]  funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm16,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        jump,
    input  logic        Branch,
    input  logic        Zero,
    output logic [31:0] pc_out
);

    typedef enum logic {
        REQ   = 1'b0,
        ISSUE = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] pc_plus4;
    logic [31:0] br_offset;
    logic [31:0] next_pc;

    always_comb begin
        pc_plus4  = pc_q + 32'd4;
        br_offset = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
        if (jump) begin
            next_pc = {pc_plus4[31:28], ir_q[25:0], 2'b00};
        end else if (Branch && Zero) begin
            next_pc = pc_plus4 + br_offset;
        end else begin
            next_pc = pc_plus4;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state_q)
            REQ: begin
                // Request is masked during reset so a held-in-reset unit never fetches.
                imem_req = ~rst;
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    pc_d    = next_pc;
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
            ir_q    <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    assign imem_addr = pc_q;
    assign pc_out    = pc_q;
    assign OpCode    = ir_q[31:26];
    assign rs        = ir_q[25:21];
    assign rt        = ir_q[20:16];
    assign rd        = ir_q[15:11];
    assign imm16     = ir_q[15:0];
    assign funct     = ir_q[5:0];

endmodule
